// File: rtl/alu_rb_sequencer.sv
// Issue-side sequencer driving reg_bank read/write controls and the ALUX start/done handshake.
// Optional ALU wait watchdog enabled by defining ALU_TIMEOUT_EN.
module alu_rb_sequencer #(
  parameter int DATA_W      = 64,
  parameter int SEL_W       = 4,
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_opr,
  input  logic [SEL_W-1:0]  instr_srcA,
  input  logic [SEL_W-1:0]  instr_srcB,
  input  logic [SEL_W-1:0]  instr_dst,
  input  logic [1:0]        instr_endw,
  input  logic              instr_cnstA,
  input  logic              instr_cnstB,
  output logic [SEL_W-1:0]  seloutA,
  output logic [SEL_W-1:0]  seloutB,
  output logic              enrregA,
  output logic              enrregB,
  output logic              cnstA,
  output logic              cnstB,
  output logic              regwen,
  output logic [SEL_W-1:0]  selwreg,
  output logic [1:0]        endwreg,
  output logic [DATA_W-1:0] inA,
  output logic [3:0]        opr,
  output logic              start,
  input  logic              done,
  input  logic [DATA_W-1:0] outAB,
  output logic              seq_done,
  output logic              seq_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] READ_LAST = 2'(READ_LAT - 1);

  state_t             state_r, nextState_s;
  logic               accept_s;
  logic [1:0]         readCnt_r;
  logic [3:0]         opr_r;
  logic [SEL_W-1:0]   srcA_r, srcB_r, dst_r;
  logic [1:0]         endw_r;
  logic               cnstA_r, cnstB_r;
  logic [3:0]         oprNxt_s;
  logic [SEL_W-1:0]   srcANxt_s, srcBNxt_s;
  logic               cnstANxt_s, cnstBNxt_s;

  logic               instrReady_s, enrreg_s, cnstA_s, cnstB_s, regwen_s, start_s;
  logic               seqDone_s, seqErr_s, busy_s;
  logic [SEL_W-1:0]   seloutA_s, seloutB_s, selwreg_s;
  logic [1:0]         endwreg_s;
  logic [3:0]         opr_s;

  assign accept_s = (state_r == ST_IDLE) && instr_valid;

`ifdef ALU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] waitCnt_r;

  // Watchdog: counts WAIT cycles, cleared while START precedes each WAIT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitCnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      waitCnt_r <= waitCnt_r + TO_W'(1);
    end else begin
      waitCnt_r <= '0;
    end
  end
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_IDLE:  if (instr_valid) nextState_s = ST_READ; else nextState_s = ST_IDLE;
      ST_READ:  if (readCnt_r == 2'd0) nextState_s = ST_START; else nextState_s = ST_READ;
      ST_START: nextState_s = ST_WAIT;
      ST_WAIT: begin
        if (done) begin
          nextState_s = ST_WRITE;
`ifdef ALU_TIMEOUT_EN
        end else if (waitCnt_r == TO_LAST) begin
          nextState_s = ST_RESP;
`endif
        end else begin
          nextState_s = ST_WAIT;
        end
      end
      ST_WRITE: nextState_s = ST_RESP;
      ST_RESP:  nextState_s = ST_IDLE;
      default:  nextState_s = ST_IDLE;
    endcase
  end

  // Instruction field latch and READ latency down-counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opr_r     <= 4'd0;
      srcA_r    <= '0;
      srcB_r    <= '0;
      dst_r     <= '0;
      endw_r    <= 2'd0;
      cnstA_r   <= 1'b0;
      cnstB_r   <= 1'b0;
      readCnt_r <= 2'd0;
    end else if (accept_s) begin
      opr_r     <= instr_opr;
      srcA_r    <= instr_srcA;
      srcB_r    <= instr_srcB;
      dst_r     <= instr_dst;
      endw_r    <= instr_endw;
      cnstA_r   <= instr_cnstA;
      cnstB_r   <= instr_cnstB;
      readCnt_r <= READ_LAST;
    end else if ((state_r == ST_READ) && (readCnt_r != 2'd0)) begin
      readCnt_r <= readCnt_r - 2'd1;
    end
  end

  // Fields as they will be after this edge, so the registered outputs line up with the state
  always_comb begin
    if (accept_s) begin
      oprNxt_s   = instr_opr;
      srcANxt_s  = instr_srcA;
      srcBNxt_s  = instr_srcB;
      cnstANxt_s = instr_cnstA;
      cnstBNxt_s = instr_cnstB;
    end else begin
      oprNxt_s   = opr_r;
      srcANxt_s  = srcA_r;
      srcBNxt_s  = srcB_r;
      cnstANxt_s = cnstA_r;
      cnstBNxt_s = cnstB_r;
    end
  end

  // Output decode from the upcoming state
  always_comb begin
    instrReady_s = 1'b0;
    enrreg_s     = 1'b0;
    seloutA_s    = '0;
    seloutB_s    = '0;
    cnstA_s      = 1'b0;
    cnstB_s      = 1'b0;
    opr_s        = 4'd0;
    start_s      = 1'b0;
    regwen_s     = 1'b0;
    selwreg_s    = '0;
    endwreg_s    = 2'd0;
    seqDone_s    = 1'b0;
    seqErr_s     = 1'b0;
    case (nextState_s)
      ST_IDLE: instrReady_s = 1'b1;
      ST_READ, ST_START, ST_WAIT: begin
        enrreg_s  = 1'b1;
        seloutA_s = srcANxt_s;
        seloutB_s = srcBNxt_s;
        cnstA_s   = cnstANxt_s;
        cnstB_s   = cnstBNxt_s;
        opr_s     = oprNxt_s;
        start_s   = (nextState_s == ST_START);
      end
      ST_WRITE: begin
        regwen_s  = 1'b1;
        selwreg_s = dst_r;
        endwreg_s = endw_r;
      end
      ST_RESP: begin
        seqDone_s = (state_r == ST_WRITE);
`ifdef ALU_TIMEOUT_EN
        seqErr_s  = (state_r == ST_WAIT);
`else
        seqErr_s  = 1'b0;
`endif
      end
      default: instrReady_s = 1'b0;
    endcase
    busy_s = (nextState_s != ST_IDLE);
  end

  // Registered outputs; an async reset drops any pending write or start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_ready <= 1'b0;
      enrregA     <= 1'b0;
      enrregB     <= 1'b0;
      seloutA     <= '0;
      seloutB     <= '0;
      cnstA       <= 1'b0;
      cnstB       <= 1'b0;
      opr         <= 4'd0;
      start       <= 1'b0;
      regwen      <= 1'b0;
      selwreg     <= '0;
      endwreg     <= 2'd0;
      seq_done    <= 1'b0;
      seq_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      instr_ready <= instrReady_s;
      enrregA     <= enrreg_s;
      enrregB     <= enrreg_s;
      seloutA     <= seloutA_s;
      seloutB     <= seloutB_s;
      cnstA       <= cnstA_s;
      cnstB       <= cnstB_s;
      opr         <= opr_s;
      start       <= start_s;
      regwen      <= regwen_s;
      selwreg     <= selwreg_s;
      endwreg     <= endwreg_s;
      seq_done    <= seqDone_s;
      seq_err     <= seqErr_s;
      busy        <= busy_s;
    end
  end

  // Result capture: done is honoured only while waiting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inA <= '0;
    end else if ((state_r == ST_WAIT) && done) begin
      inA <= outAB;
    end
  end

endmodule

// File: tb/tb_alu_rb_sequencer.sv
// Directed bench for alu_rb_sequencer: a READ_LAT=1 instance and a READ_LAT=3 instance.
module tb_alu_rb_sequencer;
  localparam int DW = 64;
  localparam int SW = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          instr_valid, instr_valid3, instr_cnstA, instr_cnstB, done, done3;
  logic [3:0]    instr_opr;
  logic [SW-1:0] instr_srcA, instr_srcB, instr_dst;
  logic [1:0]    instr_endw;
  logic [DW-1:0] outAB;

  logic          instr_ready, enrregA, enrregB, cnstA, cnstB, regwen, start, seq_done, seq_err, busy;
  logic [SW-1:0] seloutA, seloutB, selwreg;
  logic [1:0]    endwreg;
  logic [3:0]    opr;
  logic [DW-1:0] inA;

  logic          r3_ready, r3_enA, r3_enB, r3_cA, r3_cB, r3_regwen, r3_start, r3_done, r3_err, r3_busy;
  logic [SW-1:0] r3_selA, r3_selB, r3_selw;
  logic [1:0]    r3_endw;
  logic [3:0]    r3_opr;
  logic [DW-1:0] r3_inA;

  int nTests = 0;
  int nFail  = 0;

  alu_rb_sequencer #(.DATA_W(DW), .SEL_W(SW), .READ_LAT(1), .TIMEOUT_CYC(16)) u1 (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opr(instr_opr), .instr_srcA(instr_srcA), .instr_srcB(instr_srcB), .instr_dst(instr_dst),
    .instr_endw(instr_endw), .instr_cnstA(instr_cnstA), .instr_cnstB(instr_cnstB),
    .seloutA(seloutA), .seloutB(seloutB), .enrregA(enrregA), .enrregB(enrregB),
    .cnstA(cnstA), .cnstB(cnstB), .regwen(regwen), .selwreg(selwreg), .endwreg(endwreg),
    .inA(inA), .opr(opr), .start(start), .done(done), .outAB(outAB),
    .seq_done(seq_done), .seq_err(seq_err), .busy(busy));

  alu_rb_sequencer #(.DATA_W(DW), .SEL_W(SW), .READ_LAT(3), .TIMEOUT_CYC(16)) u3 (
    .clock(clock), .reset(reset), .instr_valid(instr_valid3), .instr_ready(r3_ready),
    .instr_opr(instr_opr), .instr_srcA(instr_srcA), .instr_srcB(instr_srcB), .instr_dst(instr_dst),
    .instr_endw(instr_endw), .instr_cnstA(instr_cnstA), .instr_cnstB(instr_cnstB),
    .seloutA(r3_selA), .seloutB(r3_selB), .enrregA(r3_enA), .enrregB(r3_enB),
    .cnstA(r3_cA), .cnstB(r3_cB), .regwen(r3_regwen), .selwreg(r3_selw), .endwreg(r3_endw),
    .inA(r3_inA), .opr(r3_opr), .start(r3_start), .done(done3), .outAB(outAB),
    .seq_done(r3_done), .seq_err(r3_err), .busy(r3_busy));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] o, input logic [SW-1:0] a, input logic [SW-1:0] b,
                           input logic [SW-1:0] d, input logic [1:0] e, input logic ca, input logic cb);
    instr_opr = o; instr_srcA = a; instr_srcB = b; instr_dst = d;
    instr_endw = e; instr_cnstA = ca; instr_cnstB = cb;
  endtask

  task automatic test_reset();
    #2;
    nTests++;
    if ({instr_ready, enrregA, enrregB, cnstA, cnstB, regwen, start, seq_done, seq_err, busy} !== 10'b0) begin
      nFail++; $display("FAIL reset_ctrl: got %b want 0", {instr_ready, enrregA, enrregB, cnstA, cnstB, regwen, start, seq_done, seq_err, busy});
    end
    nTests++;
    if ({seloutA, seloutB, selwreg, endwreg, opr} !== 18'b0 || inA !== 64'd0) begin
      nFail++; $display("FAIL reset_data: sel=%h/%h/%h endw=%h opr=%h inA=%h want 0", seloutA, seloutB, selwreg, endwreg, opr, inA);
    end
    @(negedge clock) reset = 1'b1;
    tick();
    nTests++;
    if ({instr_ready, busy, r3_ready} !== 3'b101) begin
      nFail++; $display("FAIL reset_release: ready/busy/r3ready=%b want 101", {instr_ready, busy, r3_ready});
    end
  endtask

  task automatic test_add();
    set_instr(4'd2, 4'd3, 4'd5, 4'd7, 2'd1, 1'b0, 1'b0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    nTests++;
    if ({instr_ready, busy, enrregA, enrregB, start, cnstA, cnstB} !== 7'b0111000 ||
        seloutA !== 4'd3 || seloutB !== 4'd5 || opr !== 4'd2) begin
      nFail++; $display("FAIL add_read: ctrl=%b selA=%0d selB=%0d opr=%0d want 0111000 3 5 2",
                        {instr_ready, busy, enrregA, enrregB, start, cnstA, cnstB}, seloutA, seloutB, opr);
    end
    tick();
    nTests++;
    if ({start, enrregA, enrregB} !== 3'b111 || seloutA !== 4'd3 || opr !== 4'd2) begin
      nFail++; $display("FAIL add_start: start/en=%b selA=%0d opr=%0d want 111 3 2", {start, enrregA, enrregB}, seloutA, opr);
    end
    set_instr(4'd9, 4'd1, 4'd1, 4'd1, 2'd3, 1'b1, 1'b1);
    tick();
    nTests++;
    if ({start, regwen, busy, enrregA} !== 4'b0011 || seloutB !== 4'd5 || opr !== 4'd2) begin
      nFail++; $display("FAIL add_wait1: ctrl=%b selB=%0d opr=%0d want 0011 5 2", {start, regwen, busy, enrregA}, seloutB, opr);
    end
    tick();
    nTests++;
    if ({start, regwen} !== 2'b00) begin
      nFail++; $display("FAIL add_wait2: start/regwen=%b want 00", {start, regwen});
    end
    done = 1'b1; outAB = 64'd2000;
    tick();
    done = 1'b0; outAB = '1;
    nTests++;
    if ({regwen, enrregA, enrregB, seq_done} !== 4'b1000 || selwreg !== 4'd7 || endwreg !== 2'd1 || inA !== 64'd2000) begin
      nFail++; $display("FAIL add_write: ctrl=%b selw=%0d endw=%0d inA=%0d want 1000 7 1 2000",
                        {regwen, enrregA, enrregB, seq_done}, selwreg, endwreg, inA);
    end
    tick();
    nTests++;
    if ({regwen, seq_done, busy} !== 3'b011 || inA !== 64'd2000) begin
      nFail++; $display("FAIL add_resp: regwen/done/busy=%b inA=%0d want 011 2000", {regwen, seq_done, busy}, inA);
    end
    tick();
    nTests++;
    if ({seq_done, busy, instr_ready} !== 3'b001) begin
      nFail++; $display("FAIL add_idle: done/busy/ready=%b want 001", {seq_done, busy, instr_ready});
    end
  endtask

  task automatic test_reset_mid_write();
    set_instr(4'd1, 4'd1, 4'd2, 4'd2, 2'd0, 1'b0, 1'b0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    done = 1'b1; outAB = 64'd55;
    tick();
    done = 1'b0;
    nTests++;
    if (regwen !== 1'b1) begin
      nFail++; $display("FAIL rstw_pre: regwen=%b want 1", regwen);
    end
    reset = 1'b0;
    #1;
    nTests++;
    if ({regwen, busy, instr_ready, start} !== 4'b0000) begin
      nFail++; $display("FAIL rstw_async: regwen/busy/ready/start=%b want 0000", {regwen, busy, instr_ready, start});
    end
    @(negedge clock) reset = 1'b1;
    tick();
    nTests++;
    if ({instr_ready, busy, regwen} !== 3'b100) begin
      nFail++; $display("FAIL rstw_release: ready/busy/regwen=%b want 100", {instr_ready, busy, regwen});
    end
  endtask

  task automatic test_held_valid();
    set_instr(4'd3, 4'd4, 4'd6, 4'd8, 2'd2, 1'b0, 1'b0);
    instr_valid = 1'b1;
    tick();
    set_instr(4'd5, 4'd10, 4'd11, 4'd12, 2'd3, 1'b0, 1'b0);
    nTests++;
    if (seloutA !== 4'd4 || opr !== 4'd3) begin
      nFail++; $display("FAIL held_first: selA=%0d opr=%0d want 4 3", seloutA, opr);
    end
    tick();
    nTests++;
    if (seloutA !== 4'd4 || instr_ready !== 1'b0) begin
      nFail++; $display("FAIL held_ignore: selA=%0d ready=%b want 4 0", seloutA, instr_ready);
    end
    tick();
    done = 1'b1; outAB = 64'd77;
    tick();
    done = 1'b0;
    nTests++;
    if (selwreg !== 4'd8 || endwreg !== 2'd2 || inA !== 64'd77) begin
      nFail++; $display("FAIL held_write1: selw=%0d endw=%0d inA=%0d want 8 2 77", selwreg, endwreg, inA);
    end
    tick();
    tick();
    nTests++;
    if (instr_ready !== 1'b1) begin
      nFail++; $display("FAIL held_idle: ready=%b want 1", instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    nTests++;
    if (seloutA !== 4'd10 || opr !== 4'd5 || busy !== 1'b1) begin
      nFail++; $display("FAIL held_second: selA=%0d opr=%0d busy=%b want 10 5 1", seloutA, opr, busy);
    end
    tick();
    tick();
    done = 1'b1; outAB = 64'd88;
    tick();
    done = 1'b0;
    nTests++;
    if (selwreg !== 4'd12 || inA !== 64'd88) begin
      nFail++; $display("FAIL held_write2: selw=%0d inA=%0d want 12 88", selwreg, inA);
    end
    tick();
    tick();
  endtask

  task automatic test_cnst();
    set_instr(4'd6, 4'd9, 4'd4, 4'd1, 2'd0, 1'b1, 1'b0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    nTests++;
    if ({cnstA, cnstB} !== 2'b10 || seloutB !== 4'd4) begin
      nFail++; $display("FAIL cnst_read: cnst=%b selB=%0d want 10 4", {cnstA, cnstB}, seloutB);
    end
    tick();
    nTests++;
    if ({cnstA, start} !== 2'b11) begin
      nFail++; $display("FAIL cnst_start: cnstA/start=%b want 11", {cnstA, start});
    end
    tick();
    nTests++;
    if ({cnstA, cnstB} !== 2'b10) begin
      nFail++; $display("FAIL cnst_wait: cnst=%b want 10", {cnstA, cnstB});
    end
    done = 1'b1; outAB = 64'hDEAD_BEEF_0123_4567;
    tick();
    done = 1'b0;
    nTests++;
    if (regwen !== 1'b1 || inA !== 64'hDEAD_BEEF_0123_4567 || selwreg !== 4'd1) begin
      nFail++; $display("FAIL cnst_write: regwen=%b inA=%h selw=%0d want 1 deadbeef01234567 1", regwen, inA, selwreg);
    end
    instr_cnstA = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int c;
    set_instr(4'd4, 4'd2, 4'd3, 4'd5, 2'd0, 1'b0, 1'b0);
    done = 1'b1; outAB = 64'd5;
    instr_valid = 1'b1;
    c = 0;
    while (seq_done !== 1'b1 && c < 20) begin tick(); c++; end
    nTests++;
    if (c >= 20) begin
      nFail++; $display("FAIL b2b_first: no seq_done within %0d cycles", c);
    end
    c = 0;
    do begin tick(); c++; end while (seq_done !== 1'b1 && c < 20);
    instr_valid = 1'b0; done = 1'b0;
    nTests++;
    if (c !== 6) begin
      nFail++; $display("FAIL b2b_period: period=%0d want 6", c);
    end
    tick();
    nTests++;
    if ({busy, instr_ready} !== 2'b01) begin
      nFail++; $display("FAIL b2b_idle: busy/ready=%b want 01", {busy, instr_ready});
    end
  endtask

  task automatic test_readlat3();
    set_instr(4'd7, 4'd1, 4'd2, 4'd3, 2'd1, 1'b0, 1'b0);
    instr_valid3 = 1'b1;
    tick();
    instr_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nTests++;
      if ({r3_enA, r3_enB, r3_start} !== 3'b110) begin
        nFail++; $display("FAIL rl3_read%0d: en/start=%b want 110", i, {r3_enA, r3_enB, r3_start});
      end
      if (i < 2) tick();
    end
    tick();
    nTests++;
    if ({r3_start, r3_enA} !== 2'b11) begin
      nFail++; $display("FAIL rl3_start: start/en=%b want 11", {r3_start, r3_enA});
    end
    done3 = 1'b1; outAB = 64'd99;
    tick();
    done3 = 1'b0;
    nTests++;
    if ({r3_start, r3_regwen, r3_busy} !== 3'b001) begin
      nFail++; $display("FAIL rl3_early_done: start/regwen/busy=%b want 001", {r3_start, r3_regwen, r3_busy});
    end
    tick();
    nTests++;
    if ({r3_regwen, r3_busy} !== 2'b01) begin
      nFail++; $display("FAIL rl3_wait: regwen/busy=%b want 01", {r3_regwen, r3_busy});
    end
    done3 = 1'b1;
    tick();
    done3 = 1'b0;
    nTests++;
    if (r3_regwen !== 1'b1 || r3_inA !== 64'd99 || r3_selw !== 4'd3) begin
      nFail++; $display("FAIL rl3_write: regwen=%b inA=%0d selw=%0d want 1 99 3", r3_regwen, r3_inA, r3_selw);
    end
    tick();
    nTests++;
    if (r3_done !== 1'b1) begin
      nFail++; $display("FAIL rl3_resp: seq_done=%b want 1", r3_done);
    end
    tick();
  endtask

`ifdef ALU_TIMEOUT_EN
  task automatic test_timeout();
    set_instr(4'd1, 4'd1, 4'd1, 4'd1, 2'd0, 1'b0, 1'b0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      nTests++;
      if ({seq_err, regwen, busy} !== 3'b001) begin
        nFail++; $display("FAIL to_wait%0d: err/regwen/busy=%b want 001", i, {seq_err, regwen, busy});
      end
    end
    tick();
    nTests++;
    if ({seq_err, seq_done, regwen, busy} !== 4'b1001) begin
      nFail++; $display("FAIL to_err: err/done/regwen/busy=%b want 1001", {seq_err, seq_done, regwen, busy});
    end
    tick();
    nTests++;
    if ({seq_err, busy, instr_ready} !== 3'b001) begin
      nFail++; $display("FAIL to_idle: err/busy/ready=%b want 001", {seq_err, busy, instr_ready});
    end
  endtask
`endif

  initial begin
    instr_valid = 1'b0; instr_valid3 = 1'b0; done = 1'b0; done3 = 1'b0; outAB = '0;
    set_instr(4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_reset_mid_write();
    test_held_valid();
    test_cnst();
    test_back_to_back();
    test_readlat3();
`ifdef ALU_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
